// File: rtl/mem_stage_pkg.sv
// Shared widths, field offsets and load-type indices for the memory-access stage.
package mem_defs;

  localparam int E_RFC_WID   = 39;
  localparam int E_MINST_WID = 5;
  localparam int EXCEPT_WID  = 7;

  // rf collection: {res_from_mem, rf_we, rf_waddr[4:0], result[31:0]}
  localparam int RFC_RES_MEM  = 38;
  localparam int RFC_WE       = 37;
  localparam int RFC_WADDR_HI = 36;
  localparam int RFC_WADDR_LO = 32;
  localparam int RFC_RES_HI   = 31;

  localparam int EXC_ALE     = 6;
  localparam int EXC_ADEF    = 5;
  localparam int EXC_INE     = 4;
  localparam int EXC_SYSCALL = 3;
  localparam int EXC_BRK     = 2;
  localparam int EXC_INT     = 1;
  localparam int EXC_ERTN    = 0;

  localparam int LD_W  = 4;
  localparam int LD_H  = 3;
  localparam int LD_HU = 2;
  localparam int LD_B  = 1;
  localparam int LD_BU = 0;

  function automatic logic [31:0] ext16(input logic [15:0] h, input logic sgn);
    return {{16{sgn & h[15]}}, h};
  endfunction

  function automatic logic [31:0] ext8(input logic [7:0] b, input logic sgn);
    return {{24{sgn & b[7]}}, b};
  endfunction

endpackage

// File: rtl/mem_stage_if.sv
// EX->MEM payload, data-SRAM response, flush and MEM->WB result bundle.
interface mem_stage_if;
  import mem_defs::*;

  logic                   es_to_ms_valid;
  logic                   ms_allowin;
  logic [31:0]            es_pc;
  logic [E_RFC_WID-1:0]   es_rf_collect;
  logic [E_MINST_WID-1:0] es_mem_inst_bus;
  logic [EXCEPT_WID-1:0]  es_except;
  logic                   es_mem_req;
  logic                   data_sram_data_ok;
  logic [31:0]            data_sram_rdata;
  logic                   except_flush;
  logic                   ws_allowin;
  logic                   ms_to_ws_valid;
  logic [31:0]            ms_pc;
  logic [E_RFC_WID-1:0]   ms_rf_collect;
  logic [EXCEPT_WID-1:0]  ms_except;

  modport master (
    output es_to_ms_valid, es_pc, es_rf_collect, es_mem_inst_bus, es_except, es_mem_req,
           data_sram_data_ok, data_sram_rdata, except_flush, ws_allowin,
    input  ms_allowin, ms_to_ws_valid, ms_pc, ms_rf_collect, ms_except
  );

  modport slave (
    input  es_to_ms_valid, es_pc, es_rf_collect, es_mem_inst_bus, es_except, es_mem_req,
           data_sram_data_ok, data_sram_rdata, except_flush, ws_allowin,
    output ms_allowin, ms_to_ws_valid, ms_pc, ms_rf_collect, ms_except
  );

endinterface

// File: rtl/mem_stage_load_align.sv
// Selects and sign/zero-extends the loaded byte, half or word from the read data.
module load_align
  import mem_defs::*;
(
  input  logic [31:0]            i_rdata,
  input  logic [1:0]             i_addr,
  input  logic [E_MINST_WID-1:0] i_ld,
  output logic [31:0]            o_result
);

  logic [7:0]  w_bytes [4];
  logic [7:0]  w_byte;
  logic [15:0] w_half;

  for (genvar gi = 0; gi < 4; gi++) begin : g_byte
    assign w_bytes[gi] = i_rdata[8*gi +: 8];
  end

  assign w_byte = w_bytes[i_addr];
  assign w_half = i_addr[1] ? i_rdata[31:16] : i_rdata[15:0];

  always_comb begin
    o_result = i_rdata;
    if (i_ld[LD_B])       o_result = ext8(w_byte, 1'b1);
    else if (i_ld[LD_BU]) o_result = ext8(w_byte, 1'b0);
    else if (i_ld[LD_H])  o_result = ext16(w_half, 1'b1);
    else if (i_ld[LD_HU]) o_result = ext16(w_half, 1'b0);
  end

endmodule

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: latches EX results, waits for load data, aligns it
// and forwards the register-write collection and exception vector.
module mem_stage
  import mem_defs::*;
(
  input  logic       clk,
  input  logic       resetn,
  mem_stage_if.slave bus
);

  logic                   r_ms_valid;
  logic [31:0]            r_pc;
  logic [E_RFC_WID-1:0]   r_rfc;
  logic [E_MINST_WID-1:0] r_minst;
  logic [EXCEPT_WID-1:0]  r_except;
  logic                   r_req_pend;
  logic                   r_data_got;
  logic [31:0]            r_data_buf;
  logic [1:0]             r_cancel_cnt;

  logic        w_data_ok_live;
  logic        w_ready_go;
  logic        w_allowin;
  logic        w_latch;
  logic        w_cancel_inc;
  logic        w_cancel_dec;
  logic [31:0] w_ld_rdata;
  logic [31:0] w_aligned;
  logic [31:0] w_final;

  // Responses owed to flushed loads are swallowed while cancel_cnt is nonzero.
  assign w_data_ok_live = bus.data_sram_data_ok & (r_cancel_cnt == 2'd0);
  assign w_ready_go     = ~r_req_pend | r_data_got | w_data_ok_live;
  assign w_allowin      = ~r_ms_valid | (w_ready_go & bus.ws_allowin);
  assign w_latch        = bus.es_to_ms_valid & w_allowin & ~bus.except_flush;
  assign w_cancel_inc   = bus.except_flush & r_ms_valid & r_req_pend & ~r_data_got & ~w_data_ok_live;
  assign w_cancel_dec   = bus.data_sram_data_ok & (r_cancel_cnt != 2'd0);
  assign w_ld_rdata     = r_data_got ? r_data_buf : bus.data_sram_rdata;

  load_align u_load_align (
    .i_rdata  (w_ld_rdata),
    .i_addr   (r_rfc[1:0]),
    .i_ld     (r_minst),
    .o_result (w_aligned)
  );

  assign w_final = (r_rfc[RFC_RES_MEM] && (r_except == '0)) ? w_aligned : r_rfc[RFC_RES_HI:0];

  assign bus.ms_allowin     = w_allowin;
  assign bus.ms_to_ws_valid = r_ms_valid & w_ready_go;
  assign bus.ms_pc          = r_pc;
  assign bus.ms_except      = r_except & {EXCEPT_WID{r_ms_valid}};
  assign bus.ms_rf_collect  = {r_rfc[RFC_RES_MEM] & r_ms_valid, r_rfc[RFC_WE] & r_ms_valid,
                               r_rfc[RFC_WADDR_HI:RFC_WADDR_LO], w_final};

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_ms_valid   <= 1'b0;
      r_pc         <= '0;
      r_rfc        <= '0;
      r_minst      <= '0;
      r_except     <= '0;
      r_req_pend   <= 1'b0;
      r_data_got   <= 1'b0;
      r_data_buf   <= '0;
      r_cancel_cnt <= 2'd0;
    end else begin
      if (bus.except_flush)  r_ms_valid <= 1'b0;
      else if (w_allowin)    r_ms_valid <= bus.es_to_ms_valid;

      if (w_latch) begin
        r_pc       <= bus.es_pc;
        r_rfc      <= bus.es_rf_collect;
        r_minst    <= bus.es_mem_inst_bus;
        r_except   <= bus.es_except;
        r_req_pend <= bus.es_mem_req;
      end

      // Hold early load data while WB stalls so the response is consumed only once.
      if (bus.except_flush || w_allowin) begin
        r_data_got <= 1'b0;
      end else if (r_ms_valid && r_req_pend && !r_data_got && w_data_ok_live) begin
        r_data_got <= 1'b1;
        r_data_buf <= bus.data_sram_rdata;
      end

      if (w_cancel_inc && !w_cancel_dec && r_cancel_cnt != 2'd3)
        r_cancel_cnt <= r_cancel_cnt + 2'd1;
      else if (w_cancel_dec && !w_cancel_inc)
        r_cancel_cnt <= r_cancel_cnt - 2'd1;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Randomized self-checking bench for mem_stage against a behavioural load/handshake model.
module tb_mem_stage;

  logic clk;
  logic resetn;
  int   checks;
  int   errors;

  mem_stage_if bus ();

  mem_stage dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // kind: 0=ld_w 1=ld_h 2=ld_hu 3=ld_b 4=ld_bu
  function automatic logic [31:0] ref_load(input logic [31:0] d, input int a, input int kind);
    logic [31:0] b;
    logic [31:0] h;
    b = (d >> (8 * a)) & 32'hFF;
    h = (d >> (16 * (a / 2))) & 32'hFFFF;
    case (kind)
      1:       return (h >= 32'h8000) ? (h | 32'hFFFF_0000) : h;
      2:       return h;
      3:       return (b >= 32'h80) ? (b | 32'hFFFF_FF00) : b;
      4:       return b;
      default: return d;
    endcase
  endfunction

  function automatic logic [4:0] kind_onehot(input int kind);
    logic [4:0] top;
    top = 5'b10000;
    return top >> kind;
  endfunction

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic send(input logic [31:0] pc, input logic [38:0] rfc, input logic [4:0] minst,
                      input logic [6:0] exc, input logic req);
    bus.es_pc           = pc;
    bus.es_rf_collect   = rfc;
    bus.es_mem_inst_bus = minst;
    bus.es_except       = exc;
    bus.es_mem_req      = req;
    bus.es_to_ms_valid  = 1'b1;
    step();
    bus.es_to_ms_valid  = 1'b0;
    bus.es_mem_req      = 1'b0;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    step();
    step();
    checks++;
    if (bus.ms_to_ws_valid !== 1'b0 || bus.ms_pc !== 32'h0 || bus.ms_rf_collect !== 39'h0 ||
        bus.ms_except !== 7'h0 || bus.ms_allowin !== 1'b1) begin
      errors++;
      $display("FAIL reset: valid=%b pc=%h rfc=%h exc=%h allowin=%b required 0/0/0/0/1",
               bus.ms_to_ws_valid, bus.ms_pc, bus.ms_rf_collect, bus.ms_except, bus.ms_allowin);
    end
    resetn = 1'b1;
    step();
  endtask

  task automatic test_alu();
    logic [31:0] res;
    logic [31:0] pc;
    logic [4:0]  wa;
    for (int i = 0; i < 8; i++) begin
      res = (i == 0) ? 32'h1234_5678 : $urandom;
      pc  = $urandom;
      wa  = 5'($urandom_range(1, 31));
      bus.ws_allowin = 1'b1;
      send(pc, {1'b0, 1'b1, wa, res}, 5'b0, 7'b0, 1'b0);
      #1;
      checks++;
      if (bus.ms_to_ws_valid !== 1'b1 || bus.ms_allowin !== 1'b1 || bus.ms_pc !== pc ||
          bus.ms_rf_collect !== {1'b0, 1'b1, wa, res}) begin
        errors++;
        $display("FAIL alu: valid=%b allowin=%b pc=%h rfc=%h required 1/1/%h/%h",
                 bus.ms_to_ws_valid, bus.ms_allowin, bus.ms_pc, bus.ms_rf_collect, pc,
                 {1'b0, 1'b1, wa, res});
      end
      $display("txn alu pc=%h result=%h", pc, res);
      step();
    end
  endtask

  task automatic test_load_latency();
    logic [31:0] d;
    logic [31:0] addr;
    logic [31:0] exp;
    logic [4:0]  wa;
    int kind;
    int wait_cycles;
    for (int i = 0; i < 20; i++) begin
      if (i == 0) begin
        kind = 3; addr = 32'h0000_1003; d = 32'h80AB_CDEF; wait_cycles = 0;
      end else if (i == 1) begin
        kind = 4; addr = 32'h0000_1003; d = 32'h80AB_CDEF; wait_cycles = 0;
      end else begin
        kind = $urandom_range(0, 4); addr = $urandom; d = $urandom;
        wait_cycles = $urandom_range(0, 3);
      end
      wa  = 5'($urandom_range(1, 31));
      exp = ref_load(d, int'(addr[1:0]), kind);
      bus.ws_allowin = 1'b1;
      send(32'h2000 + 32'(i * 4), {1'b1, 1'b1, wa, addr}, kind_onehot(kind), 7'b0, 1'b1);
      for (int w = 0; w < wait_cycles; w++) begin
        bus.data_sram_rdata = $urandom;
        #1;
        checks++;
        if (bus.ms_to_ws_valid !== 1'b0 || bus.ms_allowin !== 1'b0) begin
          errors++;
          $display("FAIL load_stall: valid=%b allowin=%b required 0/0", bus.ms_to_ws_valid,
                   bus.ms_allowin);
        end
        step();
      end
      bus.data_sram_data_ok = 1'b1;
      bus.data_sram_rdata   = d;
      #1;
      checks++;
      if (bus.ms_to_ws_valid !== 1'b1 || bus.ms_allowin !== 1'b1 ||
          bus.ms_rf_collect !== {1'b1, 1'b1, wa, exp}) begin
        errors++;
        $display("FAIL load: kind=%0d valid=%b allowin=%b rfc=%h required 1/1/%h", kind,
                 bus.ms_to_ws_valid, bus.ms_allowin, bus.ms_rf_collect, {1'b1, 1'b1, wa, exp});
      end
      $display("txn load kind=%0d addr=%h data=%h stall=%0d result=%h", kind, addr, d,
               wait_cycles, exp);
      step();
      bus.data_sram_data_ok = 1'b0;
      checks++;
      if (bus.ms_to_ws_valid !== 1'b0) begin
        errors++;
        $display("FAIL load_leave: valid=%b required 0", bus.ms_to_ws_valid);
      end
    end
  endtask

  task automatic test_buffered();
    logic [31:0] exp;
    exp = ref_load(32'h8001_7FFF, 2, 1);
    bus.ws_allowin = 1'b0;
    send(32'h3000, {1'b1, 1'b1, 5'd7, 32'h0000_4002}, kind_onehot(1), 7'b0, 1'b1);
    bus.data_sram_data_ok = 1'b1;
    bus.data_sram_rdata   = 32'h8001_7FFF;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++;
      if (bus.ms_to_ws_valid !== 1'b1 || bus.ms_allowin !== 1'b0 ||
          bus.ms_rf_collect !== {1'b1, 1'b1, 5'd7, exp}) begin
        errors++;
        $display("FAIL buffered_hold: cycle=%0d valid=%b allowin=%b rfc=%h required 1/0/%h", c,
                 bus.ms_to_ws_valid, bus.ms_allowin, bus.ms_rf_collect, {1'b1, 1'b1, 5'd7, exp});
      end
      step();
      bus.data_sram_data_ok = 1'b0;
      bus.data_sram_rdata   = $urandom;
    end
    bus.ws_allowin = 1'b1;
    #1;
    checks++;
    if (bus.ms_to_ws_valid !== 1'b1 || bus.ms_allowin !== 1'b1 ||
        bus.ms_rf_collect !== {1'b1, 1'b1, 5'd7, exp}) begin
      errors++;
      $display("FAIL buffered_release: valid=%b allowin=%b rfc=%h required 1/1/%h",
               bus.ms_to_ws_valid, bus.ms_allowin, bus.ms_rf_collect, {1'b1, 1'b1, 5'd7, exp});
    end
    $display("txn buffered ld_h result=%h", exp);
    step();
    checks++;
    if (bus.ms_to_ws_valid !== 1'b0 || bus.ms_allowin !== 1'b1) begin
      errors++;
      $display("FAIL buffered_leave: valid=%b allowin=%b required 0/1", bus.ms_to_ws_valid,
               bus.ms_allowin);
    end
  endtask

  task automatic test_flush();
    bus.ws_allowin = 1'b1;
    send(32'h4000, {1'b1, 1'b1, 5'd3, 32'h0000_5000}, kind_onehot(0), 7'b0, 1'b1);
    bus.except_flush = 1'b1;
    step();
    bus.except_flush = 1'b0;
    checks++;
    if (bus.ms_to_ws_valid !== 1'b0 || bus.ms_allowin !== 1'b1) begin
      errors++;
      $display("FAIL flush_empty: valid=%b allowin=%b required 0/1", bus.ms_to_ws_valid,
               bus.ms_allowin);
    end
    send(32'h4004, {1'b1, 1'b1, 5'd4, 32'h0000_6000}, kind_onehot(0), 7'b0, 1'b1);
    bus.data_sram_data_ok = 1'b1;
    bus.data_sram_rdata   = 32'hDEAD_BEEF;
    #1;
    checks++;
    if (bus.ms_to_ws_valid !== 1'b0 || bus.ms_allowin !== 1'b0) begin
      errors++;
      $display("FAIL flush_drop: valid=%b allowin=%b required 0/0", bus.ms_to_ws_valid,
               bus.ms_allowin);
    end
    step();
    bus.data_sram_rdata = 32'h0000_0042;
    #1;
    checks++;
    if (bus.ms_to_ws_valid !== 1'b1 || bus.ms_rf_collect !== {1'b1, 1'b1, 5'd4, 32'h42}) begin
      errors++;
      $display("FAIL flush_next: valid=%b rfc=%h required 1/%h", bus.ms_to_ws_valid,
               bus.ms_rf_collect, {1'b1, 1'b1, 5'd4, 32'h42});
    end
    $display("txn flush then ld_w result=%h", 32'h42);
    step();
    bus.data_sram_data_ok = 1'b0;
    // flush wins over a same-cycle latch
    bus.es_pc = 32'h4100; bus.es_rf_collect = {1'b0, 1'b1, 5'd9, 32'h99};
    bus.es_mem_inst_bus = 5'b0; bus.es_except = 7'b0; bus.es_mem_req = 1'b0;
    bus.es_to_ms_valid = 1'b1;
    bus.except_flush   = 1'b1;
    step();
    bus.es_to_ms_valid = 1'b0;
    bus.except_flush   = 1'b0;
    checks++;
    if (bus.ms_to_ws_valid !== 1'b0) begin
      errors++;
      $display("FAIL flush_priority: valid=%b required 0", bus.ms_to_ws_valid);
    end
  endtask

  task automatic test_except();
    logic [31:0] addr;
    logic [6:0]  exc;
    for (int i = 0; i < 6; i++) begin
      addr = (i == 0) ? 32'h0000_1003 : $urandom;
      exc  = (i == 0) ? 7'b100_0000 : 7'(1 << $urandom_range(0, 6));
      bus.ws_allowin = 1'b1;
      bus.data_sram_rdata = $urandom;
      send(32'h5000, {1'b1, 1'b1, 5'd5, addr}, kind_onehot(0), exc, 1'b0);
      #1;
      checks++;
      if (bus.ms_except !== exc || bus.ms_to_ws_valid !== 1'b1 || bus.ms_allowin !== 1'b1 ||
          bus.ms_rf_collect !== {1'b1, 1'b1, 5'd5, addr}) begin
        errors++;
        $display("FAIL except: exc=%b valid=%b allowin=%b rfc=%h required %b/1/1/%h",
                 bus.ms_except, bus.ms_to_ws_valid, bus.ms_allowin, bus.ms_rf_collect, exc,
                 {1'b1, 1'b1, 5'd5, addr});
      end
      $display("txn except vec=%b addr=%h", exc, addr);
      step();
    end
  endtask

  task automatic test_reset_mid_stall();
    bus.ws_allowin = 1'b1;
    send(32'h6000, {1'b1, 1'b1, 5'd6, 32'h0000_7001}, kind_onehot(3), 7'b0, 1'b1);
    #1;
    checks++;
    if (bus.ms_allowin !== 1'b0) begin
      errors++;
      $display("FAIL stall_before_reset: allowin=%b required 0", bus.ms_allowin);
    end
    resetn = 1'b0;
    step();
    checks++;
    if (bus.ms_to_ws_valid !== 1'b0 || bus.ms_pc !== 32'h0 || bus.ms_rf_collect !== 39'h0 ||
        bus.ms_except !== 7'h0 || bus.ms_allowin !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_stall: valid=%b pc=%h rfc=%h exc=%h allowin=%b required 0/0/0/0/1",
               bus.ms_to_ws_valid, bus.ms_pc, bus.ms_rf_collect, bus.ms_except, bus.ms_allowin);
    end
    resetn = 1'b1;
    step();
    send(32'h6004, {1'b1, 1'b1, 5'd8, 32'h0000_7000}, kind_onehot(0), 7'b0, 1'b1);
    bus.data_sram_data_ok = 1'b1;
    bus.data_sram_rdata   = 32'h77;
    #1;
    checks++;
    if (bus.ms_to_ws_valid !== 1'b1 || bus.ms_rf_collect !== {1'b1, 1'b1, 5'd8, 32'h77}) begin
      errors++;
      $display("FAIL post_reset_load: valid=%b rfc=%h required 1/%h", bus.ms_to_ws_valid,
               bus.ms_rf_collect, {1'b1, 1'b1, 5'd8, 32'h77});
    end
    step();
    bus.data_sram_data_ok = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic        m_valid;
    logic [31:0] m_pc;
    logic [31:0] m_res;
    logic [4:0]  m_wa;
    logic [31:0] n_res;
    logic [4:0]  n_wa;
    logic        ws;
    int accepted;
    m_valid = 1'b0; m_pc = '0; m_res = '0; m_wa = '0;
    accepted = 0;
    n_res = $urandom;
    n_wa  = 5'($urandom_range(1, 31));
    for (int c = 0; c < 80 && accepted < 12; c++) begin
      ws = 1'($urandom_range(0, 1));
      bus.ws_allowin      = ws;
      bus.es_pc           = 32'h8000 + 32'(accepted * 4);
      bus.es_rf_collect   = {1'b0, 1'b1, n_wa, n_res};
      bus.es_mem_inst_bus = 5'b0;
      bus.es_except       = 7'b0;
      bus.es_mem_req      = 1'b0;
      bus.es_to_ms_valid  = 1'b1;
      #1;
      checks++;
      if (bus.ms_allowin !== (!m_valid || ws) || bus.ms_to_ws_valid !== m_valid ||
          (m_valid && (bus.ms_pc !== m_pc || bus.ms_rf_collect !== {1'b0, 1'b1, m_wa, m_res}))) begin
        errors++;
        $display("FAIL back_to_back: allowin=%b valid=%b pc=%h rfc=%h required %b/%b/%h/%h",
                 bus.ms_allowin, bus.ms_to_ws_valid, bus.ms_pc, bus.ms_rf_collect,
                 (!m_valid || ws), m_valid, m_pc, {1'b0, 1'b1, m_wa, m_res});
      end
      if (!m_valid || ws) begin
        m_valid = 1'b1;
        m_pc    = 32'h8000 + 32'(accepted * 4);
        m_res   = n_res;
        m_wa    = n_wa;
        accepted++;
        n_res = $urandom;
        n_wa  = 5'($urandom_range(1, 31));
        $display("txn b2b accept pc=%h result=%h", m_pc, m_res);
      end
      step();
    end
    bus.es_to_ms_valid = 1'b0;
    checks++;
    if (accepted < 12) begin
      errors++;
      $display("FAIL back_to_back_budget: accepted=%0d required 12", accepted);
    end
    bus.ws_allowin = 1'b1;
    step();
    checks++;
    if (bus.ms_to_ws_valid !== 1'b0) begin
      errors++;
      $display("FAIL back_to_back_drain: valid=%b required 0", bus.ms_to_ws_valid);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    resetn                = 1'b0;
    bus.es_to_ms_valid    = 1'b0;
    bus.es_pc             = '0;
    bus.es_rf_collect     = '0;
    bus.es_mem_inst_bus   = '0;
    bus.es_except         = '0;
    bus.es_mem_req        = 1'b0;
    bus.data_sram_data_ok = 1'b0;
    bus.data_sram_rdata   = '0;
    bus.except_flush      = 1'b0;
    bus.ws_allowin        = 1'b1;
    @(negedge clk);
    test_reset();
    test_alu();
    test_load_latency();
    test_buffered();
    test_flush();
    test_except();
    test_reset_mid_stall();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access pipeline stage between the execute stage and write-back. Latches the execute stage's result bus on handshake. For loads whose data-SRAM request was accepted upstream, it waits for `data_sram_data_ok`, buffers the read data and aligns/extends it. It forwards the register-write collection and exception vector downstream and back to EX. On `except_flush` it invalidates itself and discards any read data still in flight.

## Interface
Parameters: none; all widths come from the shared package.

Ports:
- `clk`  in  1  system clock
- `resetn`  in  1  synchronous active-low reset
- `es_to_ms_valid`  in  1  EX has an instruction for MEM
- `ms_allowin`  out  1  MEM can accept this cycle
- `es_pc`  in  32  PC of the EX instruction
- `es_rf_collect`  in  39  {res_from_mem, rf_we, rf_waddr[4:0], result[31:0]}; for memory ops, result = byte address
- `es_mem_inst_bus`  in  5  {ld_w, ld_h, ld_hu, ld_b, ld_bu}
- `es_except`  in  7  {ale, adef, ine, syscall, brk, int, ertn}
- `es_mem_req`  in  1  this instruction's data-SRAM request was accepted (addr_ok seen)
- `data_sram_data_ok`  in  1  read/write response valid
- `data_sram_rdata`  in  32  read data, valid with data_ok
- `except_flush`  in  1  WB exception/ertn flush
- `ws_allowin`  in  1  WB can accept
- `ms_to_ws_valid`  out  1  MEM result valid to WB
- `ms_pc`  out  32  latched PC
- `ms_rf_collect`  out  39  {res_from_mem&valid, rf_we&valid, rf_waddr, ms_final_result}
- `ms_except`  out  7  latched exception vector & ms_valid, to EX and WB

## Operation
- Latch: `ms_valid` <= `es_to_ms_valid` when `ms_allowin`. Payload registers load when `es_to_ms_valid & ms_allowin`.
- `ms_allowin = ~ms_valid | (ms_ready_go & ws_allowin)`.
- `ms_ready_go = ~req_pend | data_got | (data_ok_live)`.
  - `req_pend` = latched `es_mem_req`.
  - `data_ok_live = data_sram_data_ok & (cancel_cnt == 0)`.
- Data buffer:
  - If `data_ok_live` arrives while `ms_valid & req_pend & ~data_got` and WB does not take the instruction, set `data_got` and store rdata in `data_buf`.
  - `data_got` clears when the instruction leaves MEM.
  - `ld_rdata` = `data_got ? data_buf : data_sram_rdata`.
- Load alignment uses `a = result[1:0]`:
  - ld_w: rdata.
  - ld_b/ld_bu: byte `rdata[8a+7:8a]`, sign-/zero-extended.
  - ld_h/ld_hu: half `rdata[16a[1]+15:16a[1]]`, sign-/zero-extended.
- `ms_final_result = res_from_mem ? aligned : result`.
- If any `ms_except` bit is set, the result is passed through unchanged. Rf_we is still forwarded; WB suppresses the write.
- Flush: `except_flush` forces `ms_valid` <= 0 and `data_got` <= 0. If `ms_valid & req_pend & ~data_got & ~data_ok_live` at the flush cycle, `cancel_cnt` increments.
- `cancel_cnt`: 2-bit, saturating at 3.
  - Decrements on each `data_sram_data_ok` while nonzero; that data_ok is dropped.
  - Simultaneous increment and decrement leaves it unchanged.
- Reset values:
  - `ms_valid`, `data_got`, `cancel_cnt`, `req_pend`: 0.
  - `ms_pc`, `data_buf` and all payload registers: 0.
  - Hence `ms_to_ws_valid`, `ms_rf_collect`, `ms_except` are all 0.

## Timing
- Non-memory instruction: one cycle in MEM when `ws_allowin` = 1.
- Load/store: data_ok in the first MEM cycle gives zero added latency; each later data_ok cycle adds one stall cycle.
- The data_ok response is consumed combinationally in the cycle it arrives, and never counted twice.
- Flush has priority over a same-cycle latch; MEM is empty the cycle after a flush.
- Reset mid-stall clears everything. Responses still on the bus after reset are the bus's responsibility.
- `ms_rf_collect` and `ms_except` are combinational from registers and `data_sram_rdata`. There is no path from `ws_allowin` to them.

## Structure
- Shared package `mem_defs`:
  - widths: E_RFC_WID = 39, E_MINST_WID = 5, EXCEPT_WID = 7;
  - field-offset constants for the rf collection and exception vector;
  - load-type one-hot indices.
- One combinational sub-module, `load_align` (rdata, addr[1:0], ld one-hot -> 32-bit result).
- State lives in the top: valid, payload, data_buf/data_got, cancel_cnt.

## Test plan
- ALU op: es result 0x1234_5678, no req, `ws_allowin`=1 -> next cycle `ms_to_ws_valid`=1, result 0x1234_5678, `ms_allowin` stays 1.
- ld_b, addr 0x...03, rdata 0x80AB_CDEF, data_ok in first cycle -> result 0xFFFF_FF80. Same with ld_bu -> 0x0000_0080.
- ld_h, addr 0x...02, rdata 0x8001_7FFF, data_ok arrives while `ws_allowin`=0 for 3 cycles -> buffered; on release result 0xFFFF_8001. A second data_ok is not awaited.
- Flush with load pending (no data_ok yet) -> `ms_valid`=0, `cancel_cnt`=1. A new load enters; first data_ok (0xDEAD_BEEF) dropped, second data_ok (0x0000_0042) gives ld_w result 0x42.
- ld_w with `es_except`=ALE (bit6), `es_mem_req`=0 -> `ms_except`=7'b100_0000, no stall, result = address.
- `resetn`=0 during a stalled load -> all outputs 0 next cycle; `cancel_cnt`=0.
